instr_seq_ctrl: RTL and testbench

- Instruction sequencing controller for the 8-bit RISC core.
- Sits directly downstream of the instruction register. It drives that register's load enable for the two-byte fetch, then decodes the 3-bit opcode (instruction bits [15:13]) over a fixed 8-phase cycle.
- Generates the PC, accumulator, memory and data-bus control strobes for every instruction.

---
 rtl/instr_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_instr_seq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// Instruction sequencing controller: runs the fixed 8-phase fetch/decode/execute
// cycle and decodes the opcode into PC, accumulator, memory and bus strobes.
//
// state          | meaning
// PH_FETCH_HI    | phase 0, fetch instruction high byte
// PH_FETCH_LO    | phase 1, fetch instruction low byte
// PH_DECODE      | phase 2, decode settle
// PH_HALT_CHK    | phase 3, HLT detect (parks here while halted_q)
// PH_EXEC_A      | phase 4, operand address / bus setup
// PH_EXEC_B      | phase 5, operand transfer / PC load
// PH_EXEC_C      | phase 6, bus hold
// PH_IDLE        | phase 7, end of instruction
module instr_seq_ctrl #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_acc,
    output logic       rd,
    output logic       wr,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_FETCH_HI = 3'd0,
        PH_FETCH_LO = 3'd1,
        PH_DECODE   = 3'd2,
        PH_HALT_CHK = 3'd3,
        PH_EXEC_A   = 3'd4,
        PH_EXEC_B   = 3'd5,
        PH_EXEC_C   = 3'd6,
        PH_IDLE     = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    phase_e  phase_q, phase_d;
    logic    halted_q, halted_d;
    opcode_e op;
    logic    acc_src;

    assign op      = opcode_e'(opcode);
    // ALU ops and LDA all read an operand from memory into the accumulator
    assign acc_src = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    assign phase   = phase_q;

    always_ff @(posedge clk1) begin
        if (rst) begin
            phase_q  <= PH_FETCH_HI;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        halted_d    = halted_q;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;

        if (halted_q) begin
            halt = 1'b1;
        end else if (ena) begin
            phase_d = phase_e'(phase_q + 3'd1);
            case (phase_q)
                PH_FETCH_HI, PH_FETCH_LO: begin
                    load_ir = 1'b1;
                    rd      = 1'b1;
                    inc_pc  = 1'b1;
                end
                PH_HALT_CHK: begin
                    if (op == OP_HLT) begin
                        halt = 1'b1;
                        if (HALT_STICKY) begin
                            halted_d = 1'b1;
                            phase_d  = phase_q;
                        end
                    end
                end
                PH_EXEC_A: begin
                    if (acc_src) rd = 1'b1;
                    if (op == OP_STO) datactl_ena = 1'b1;
                    if (op == OP_JMP) load_pc = 1'b1;
                    if (op == OP_SKZ && zero) inc_pc = 1'b1;
                end
                PH_EXEC_B: begin
                    if (acc_src) begin
                        rd       = 1'b1;
                        load_acc = 1'b1;
                    end
                    if (op == OP_STO) begin
                        wr          = 1'b1;
                        datactl_ena = 1'b1;
                    end
                    // JMP reloads the PC, then steps once past the loaded address
                    if (op == OP_JMP) begin
                        load_pc = 1'b1;
                        inc_pc  = 1'b1;
                    end
                    if (op == OP_SKZ && zero) inc_pc = 1'b1;
                end
                PH_EXEC_C: begin
                    if (acc_src) rd = 1'b1;
                    if (op == OP_STO) datactl_ena = 1'b1;
                end
                default: ;
            endcase
        end else begin
            phase_d = PH_FETCH_HI;
        end
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: expected strobe vectors are queued when
// inputs are driven and compared against the DUT mid-cycle.
module tb_instr_seq_ctrl;

    logic       clk1 = 1'b0;
    logic       rst, ena, zero;
    logic [2:0] opcode;
    logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;
    int inc_cnt = 0;

    logic [10:0] sb_q[$];
    logic [2:0]  m_phase;
    logic        m_halted;

    instr_seq_ctrl #(.HALT_STICKY(1'b1)) dut (
        .clk1(clk1), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
        .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
        .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .phase(phase)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Vector layout: {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, phase}
    function automatic logic [10:0] ref_out(input logic [2:0] ph, input logic hd,
                                            input logic en, input logic [2:0] op,
                                            input logic z);
        logic [7:0] c;
        logic       acc;
        c   = 8'b0;
        acc = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
        if (hd) begin
            c = 8'b0000_0001;
        end else if (en) begin
            case (ph)
                3'd0, 3'd1: c = 8'b1100_1000;
                3'd3: if (op == 3'b000) c = 8'b0000_0001;
                3'd4: begin
                    if (acc)                    c = 8'b0000_1000;
                    else if (op == 3'b110)      c = 8'b0000_0010;
                    else if (op == 3'b111)      c = 8'b0010_0000;
                    else if (op == 3'b001 && z) c = 8'b0100_0000;
                end
                3'd5: begin
                    if (acc)                    c = 8'b0001_1000;
                    else if (op == 3'b110)      c = 8'b0000_0110;
                    else if (op == 3'b111)      c = 8'b0110_0000;
                    else if (op == 3'b001 && z) c = 8'b0100_0000;
                end
                3'd6: begin
                    if (acc)               c = 8'b0000_1000;
                    else if (op == 3'b110) c = 8'b0000_0010;
                end
                default: c = 8'b0;
            endcase
        end
        return {c, ph};
    endfunction

    // One clock: drive at posedge+1, push expectation, compare at negedge, advance model
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [2:0] op, input logic z);
        logic [10:0] got;
        rst = r; ena = e; opcode = op; zero = z;
        sb_q.push_back(ref_out(m_phase, m_halted, e, op, z));
        @(negedge clk1);
        got = {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, phase};
        if (inc_pc === 1'b1) inc_cnt++;
        check_eq(tag, got, sb_q.pop_front());
        @(posedge clk1);
        if (r) begin
            m_phase = 3'd0; m_halted = 1'b0;
        end else if (m_halted) begin
        end else if (!e) begin
            m_phase = 3'd0;
        end else if (m_phase == 3'd3 && op == 3'b000) begin
            m_halted = 1'b1;
        end else begin
            m_phase = m_phase + 3'd1;
        end
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic z);
        for (int i = 0; i < 8; i++) step(tag, 1'b0, 1'b1, op, z);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; opcode = 3'b010; zero = 1'b0;
        m_phase = 3'd0; m_halted = 1'b0;
        @(posedge clk1); #1;

        step("reset0", 1'b1, 1'b0, 3'b010, 1'b0);
        step("reset1", 1'b1, 1'b0, 3'b010, 1'b0);
        step("idle",   1'b0, 1'b0, 3'b010, 1'b0);

        run_instr("ADD", 3'b010, 1'b0);
        run_instr("AND", 3'b011, 1'b1);
        run_instr("XOR", 3'b100, 1'b0);
        run_instr("LDA", 3'b101, 1'b1);
        run_instr("STO", 3'b110, 1'b0);

        inc_cnt = 0;
        run_instr("SKZ_z1", 3'b001, 1'b1);
        check_eq("SKZ_z1_incs", 11'(inc_cnt), 11'd4);
        inc_cnt = 0;
        for (int i = 0; i < 8; i++)
            step("SKZ_z0", 1'b0, 1'b1, 3'b001, (i == 4 || i == 5) ? 1'b0 : 1'b1);
        check_eq("SKZ_z0_incs", 11'(inc_cnt), 11'd2);
        inc_cnt = 0;
        run_instr("JMP", 3'b111, 1'b0);
        check_eq("JMP_incs", 11'(inc_cnt), 11'd3);

        // Mid-op disruption: drop ena at phase 5 of an ADD
        for (int i = 0; i < 5; i++) step("ADD_pre", 1'b0, 1'b1, 3'b010, 1'b0);
        step("ADD_p5_ena0", 1'b0, 1'b0, 3'b010, 1'b0);
        step("ena0_hold",   1'b0, 1'b0, 3'b010, 1'b0);
        check_eq("ena0_phase", 11'(phase), 11'd0);

        // rst at phase 6 of a STO
        for (int i = 0; i < 6; i++) step("STO_pre", 1'b0, 1'b1, 3'b110, 1'b0);
        step("STO_p6_rst", 1'b1, 1'b1, 3'b110, 1'b0);
        step("after_rst",  1'b0, 1'b0, 3'b110, 1'b0);
        run_instr("refetch", 3'b110, 1'b0);

        // Sticky halt with ena toggling
        for (int i = 0; i < 4; i++) step("HLT_run", 1'b0, 1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++)
            step("HLT_park", 1'b0, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                 1'($urandom_range(1, 0)));
        check_eq("HLT_phase", 11'(phase), 11'd3);
        step("HLT_rst",   1'b1, 1'b1, 3'b000, 1'b0);
        step("HLT_clear", 1'b0, 1'b0, 3'b000, 1'b0);
        run_instr("post_halt", 3'b010, 1'b0);

        check_eq("sb_empty", 11'(sb_q.size()), 11'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
